// File: rtl/regfile_pkg.sv
// Shared constants, select-width helper and word/index types for the
// multi-port register file.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    // Select width for a register count; never narrower than one bit.
    function automatic int sel_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int DEF_AW = sel_width(DEF_NREGS);

    typedef logic [DEF_XLEN-1:0] reg_word_t;
    typedef logic [DEF_AW-1:0]   reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector tracking in-flight writes. Issue sets a bit,
// a write clears it, and a same-edge issue beats the clear so the newest
// producer stays tracked.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int ZERO_REG = 1,
    parameter int AW       = sel_width(NREGS)
) (
    input  logic             clk_tb,
    input  logic             n_rst_tb,
    input  logic [NREGS-1:0] wr_clr,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_sel,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] iss_set;
    logic [NREGS-1:0] busy_nxt;

    // Decode the issue index; register 0 is never tracked when hardwired.
    always_comb begin
        iss_set = '0;
        if (iss_en)
            iss_set[iss_sel] = 1'b1;
        if (ZERO_REG != 0)
            iss_set[0] = 1'b0;
    end

    assign busy_nxt = (busy & ~wr_clr) | iss_set;

    // Busy state, cleared asynchronously on reset.
    always_ff @(posedge clk_tb or posedge n_rst_tb) begin
        if (n_rst_tb)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD registered read ports, NWR write
// ports (highest port wins on collision), optional hardwired zero register
// and a busy scoreboard for pending writes.
// Optional feature: define REGFILE_BYPASS_EN to forward same-edge write
// data and busy clears to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = sel_width(NREGS)
) (
    input  logic                      clk_tb,
    input  logic                      n_rst_tb,
    input  logic [NRD-1:0]            rd_en,
    input  logic [NRD-1:0][AW-1:0]    rd_sel,
    output logic [NRD-1:0][XLEN-1:0]  rd_data,
    output logic [NRD-1:0]            rd_valid,
    output logic [NRD-1:0]            rd_busy,
    input  logic [NWR-1:0]            wr_en,
    input  logic [NWR-1:0][AW-1:0]    wr_sel,
    input  logic [NWR-1:0][XLEN-1:0]  wr_data,
    input  logic                      iss_en,
    input  logic [AW-1:0]             iss_sel,
    output logic [NREGS-1:0]          busy
);

    localparam int RD_STAGES = 1;

    logic [NREGS-1:0][XLEN-1:0] mem;
    logic [NREGS-1:0][XLEN-1:0] mem_nxt;
    logic [NREGS-1:0]           wr_clr;
    logic [NREGS-1:0][XLEN-1:0] rd_view;
    logic [NREGS-1:0]           busy_view;
    logic [RD_STAGES:1][NRD-1:0] vld_pipe;

    // Fold all write ports into next-state storage; later ports overwrite
    // earlier ones so the highest index wins a collision.
    always_comb begin
        mem_nxt = mem;
        wr_clr  = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && !((ZERO_REG != 0) && (wr_sel[w] == '0))) begin
                mem_nxt[wr_sel[w]] = wr_data[w];
                wr_clr[wr_sel[w]]  = 1'b1;
            end
        end
    end

    // Register storage, cleared asynchronously on reset.
    always_ff @(posedge clk_tb or posedge n_rst_tb) begin
        if (n_rst_tb)
            mem <= '0;
        else
            mem <= mem_nxt;
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .clk_tb   (clk_tb),
        .n_rst_tb (n_rst_tb),
        .wr_clr   (wr_clr),
        .iss_en   (iss_en),
        .iss_sel  (iss_sel),
        .busy     (busy)
    );

`ifdef REGFILE_BYPASS_EN
    // Reads see this edge's writes and the busy clears they cause.
    assign rd_view   = mem_nxt;
    assign busy_view = busy & ~wr_clr;
`else
    // Reads see pre-edge contents and busy state.
    assign rd_view   = mem;
    assign busy_view = busy;
`endif

    // Read-valid pipeline: rd_en delayed by the read latency.
    always_ff @(posedge clk_tb or posedge n_rst_tb) begin
        if (n_rst_tb) begin
            vld_pipe <= '0;
        end else begin
            for (int s = RD_STAGES; s > 1; s--)
                vld_pipe[s] <= vld_pipe[s-1];
            vld_pipe[1] <= rd_en;
        end
    end

    assign rd_valid = vld_pipe[RD_STAGES];

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [XLEN-1:0] rdat;
        logic            rbsy;
        logic [XLEN-1:0] rdat_q;
        logic            rbsy_q;

        // Select the word and hazard flag; register 0 forced clean when hardwired.
        always_comb begin
            rdat = rd_view[rd_sel[p]];
            rbsy = busy_view[rd_sel[p]];
            if ((ZERO_REG != 0) && (rd_sel[p] == '0)) begin
                rdat = '0;
                rbsy = 1'b0;
            end
        end

        // Capture on an enabled read; hold otherwise.
        always_ff @(posedge clk_tb or posedge n_rst_tb) begin
            if (n_rst_tb) begin
                rdat_q <= '0;
                rbsy_q <= 1'b0;
            end else if (rd_en[p]) begin
                rdat_q <= rdat;
                rbsy_q <= rbsy;
            end
        end

        assign rd_data[p] = rdat_q;
        assign rd_busy[p] = rbsy_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NRD=2, NWR=2, ZERO_REG=1). Read
// expectations are queued when a read is driven and compared one cycle later.
// Bypass-dependent expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic              clk_tb = 1'b0;
    logic              n_rst_tb = 1'b1;
    logic [1:0]        rd_en;
    logic [1:0][4:0]   rd_sel;
    logic [1:0][31:0]  rd_data;
    logic [1:0]        rd_valid;
    logic [1:0]        rd_busy;
    logic [1:0]        wr_en;
    logic [1:0][4:0]   wr_sel;
    logic [1:0][31:0]  wr_data;
    logic              iss_en;
    logic [4:0]        iss_sel;
    logic [31:0]       busy;

    typedef struct {
        int        port;
        reg_word_t data;
        logic      bsy;
    } exp_t;

    exp_t       expq[$];
    reg_word_t  model[32];
    logic [31:0] mbusy;
    logic [1:0] exp_vld;
    int checks   = 0;
    int failures = 0;

    regfile_mp #(
        .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)
    ) dut (
        .clk_tb   (clk_tb),
        .n_rst_tb (n_rst_tb),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_sel  (iss_sel),
        .busy     (busy)
    );

    always #5 clk_tb = ~clk_tb;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle();
        rd_en   = '0;
        rd_sel  = '0;
        wr_en   = '0;
        wr_sel  = '0;
        wr_data = '0;
        iss_en  = 1'b0;
        iss_sel = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
        mbusy = '0;
        expq.delete();
    endtask

    // Model one edge from the currently driven inputs, queue read
    // expectations, then advance to 1 time unit past the edge.
    task automatic apply();
        reg_word_t   nxt[32];
        logic [31:0] clr;
        logic [31:0] set;
        exp_t        e;
        logic [4:0]  s;
        nxt = model;
        clr = '0;
        set = '0;
        for (int w = 0; w < 2; w++) begin
            if (wr_en[w] && wr_sel[w] != 5'd0) begin
                nxt[wr_sel[w]] = wr_data[w];
                clr[wr_sel[w]] = 1'b1;
            end
        end
        if (iss_en && iss_sel != 5'd0) set[iss_sel] = 1'b1;
        for (int p = 0; p < 2; p++) begin
            if (rd_en[p]) begin
                s = rd_sel[p];
                e.port = p;
`ifdef REGFILE_BYPASS_EN
                e.data = nxt[s];
                e.bsy  = mbusy[s] & ~clr[s];
`else
                e.data = model[s];
                e.bsy  = mbusy[s];
`endif
                if (s == 5'd0) begin
                    e.data = '0;
                    e.bsy  = 1'b0;
                end
                expq.push_back(e);
            end
        end
        exp_vld = rd_en;
        model = nxt;
        mbusy = (mbusy & ~clr) | set;
        @(posedge clk_tb);
        #1;
    endtask

    task automatic test_reset();
        idle();
        n_rst_tb = 1'b1;
        model_clear();
        repeat (3) @(posedge clk_tb);
        #1;
        checks++;
        if (rd_data !== '0 || rd_valid !== 2'b00 || rd_busy !== 2'b00 || busy !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got data=%h valid=%b rbusy=%b busy=%h want all zero",
                     rd_data, rd_valid, rd_busy, busy);
        end
        n_rst_tb = 1'b0;
    endtask

    task automatic test_read_all();
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            idle();
            rd_en     = 2'b11;
            rd_sel[0] = 5'(i);
            rd_sel[1] = 5'(31 - i);
            apply();
            while (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (rd_valid[e.port] !== 1'b1 || rd_data[e.port] !== e.data || rd_busy[e.port] !== e.bsy) begin
                    failures++;
                    $display("FAIL read_all idx=%0d port=%0d got v=%b d=%h b=%b want v=1 d=%h b=%b",
                             i, e.port, rd_valid[e.port], rd_data[e.port], rd_busy[e.port], e.data, e.bsy);
                end
            end
        end
        idle();
        apply();
        checks++;
        if (rd_valid !== 2'b00 || rd_data !== '0 || busy !== 32'h0) begin
            failures++;
            $display("FAIL read_idle got valid=%b data=%h busy=%h want valid=00 data=0 busy=0",
                     rd_valid, rd_data, busy);
        end
    endtask

    task automatic test_write_all();
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            idle();
            wr_en[0]   = 1'b1;
            wr_sel[0]  = 5'(i);
            wr_data[0] = 32'(i + 2);
            apply();
        end
        for (int i = 0; i < 32; i++) begin
            idle();
            rd_en     = 2'b11;
            rd_sel[0] = 5'(i);
            rd_sel[1] = 5'((i + 7) % 32);
            apply();
            while (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (rd_valid[e.port] !== 1'b1 || rd_data[e.port] !== e.data || rd_busy[e.port] !== e.bsy) begin
                    failures++;
                    $display("FAIL write_all idx=%0d port=%0d got v=%b d=%h b=%b want v=1 d=%h b=%b",
                             i, e.port, rd_valid[e.port], rd_data[e.port], rd_busy[e.port], e.data, e.bsy);
                end
            end
        end
        idle();
        rd_en     = 2'b11;
        rd_sel[0] = 5'd0;
        rd_sel[1] = 5'd5;
        apply();
        expq.delete();
        checks++;
        if (rd_data[0] !== 32'h0 || rd_data[1] !== 32'h7) begin
            failures++;
            $display("FAIL zero_and_r5 got r0=%h r5=%h want r0=0 r5=7", rd_data[0], rd_data[1]);
        end
        idle();
        rd_en[1]  = 1'b1;
        rd_sel[1] = 5'd31;
        apply();
        expq.delete();
        checks++;
        if (rd_data[1] !== 32'h21 || rd_data[0] !== 32'h0) begin
            failures++;
            $display("FAIL r31_hold got r31=%h p0=%h want r31=21 p0=0", rd_data[1], rd_data[0]);
        end
    endtask

    task automatic test_collision();
        idle();
        wr_en      = 2'b11;
        wr_sel[0]  = 5'd3;
        wr_sel[1]  = 5'd3;
        wr_data[0] = 32'hAAAA;
        wr_data[1] = 32'h5555;
        apply();
        idle();
        rd_en     = 2'b11;
        rd_sel[0] = 5'd3;
        rd_sel[1] = 5'd3;
        apply();
        expq.delete();
        checks++;
        if (rd_data[0] !== 32'h5555 || rd_data[1] !== 32'h5555) begin
            failures++;
            $display("FAIL collision got p0=%h p1=%h want 5555", rd_data[0], rd_data[1]);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want_d;
        logic        want_b;
`ifdef REGFILE_BYPASS_EN
        want_d = 32'hDEADBEEF;
        want_b = 1'b0;
`else
        want_d = 32'h9;
        want_b = 1'b1;
`endif
        idle();
        iss_en  = 1'b1;
        iss_sel = 5'd7;
        apply();
        idle();
        wr_en[0]   = 1'b1;
        wr_sel[0]  = 5'd7;
        wr_data[0] = 32'hDEADBEEF;
        rd_en[0]   = 1'b1;
        rd_sel[0]  = 5'd7;
        apply();
        expq.delete();
        checks++;
        if (rd_data[0] !== want_d || rd_busy[0] !== want_b) begin
            failures++;
            $display("FAIL same_edge_rw got d=%h b=%b want d=%h b=%b", rd_data[0], rd_busy[0], want_d, want_b);
        end
        idle();
        rd_en[0]  = 1'b1;
        rd_sel[0] = 5'd7;
        apply();
        expq.delete();
        checks++;
        if (rd_data[0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0 || busy[7] !== 1'b0) begin
            failures++;
            $display("FAIL after_rw got d=%h b=%b busy7=%b want d=deadbeef b=0 busy7=0",
                     rd_data[0], rd_busy[0], busy[7]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_en  = 1'b1;
        iss_sel = 5'd9;
        apply();
        idle();
        rd_en[1]  = 1'b1;
        rd_sel[1] = 5'd9;
        apply();
        expq.delete();
        checks++;
        if (rd_busy[1] !== 1'b1 || busy[9] !== 1'b1) begin
            failures++;
            $display("FAIL issue_busy got rd_busy=%b busy9=%b want 1 1", rd_busy[1], busy[9]);
        end
        idle();
        wr_en[0]   = 1'b1;
        wr_sel[0]  = 5'd9;
        wr_data[0] = 32'h99;
        iss_en     = 1'b1;
        iss_sel    = 5'd9;
        apply();
        checks++;
        if (busy[9] !== 1'b1) begin
            failures++;
            $display("FAIL issue_beats_clear got busy9=%b want 1", busy[9]);
        end
        idle();
        iss_en  = 1'b1;
        iss_sel = 5'd0;
        apply();
        checks++;
        if (busy !== mbusy || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL issue_r0 got busy=%h want %h", busy, mbusy);
        end
        idle();
        wr_en[1]   = 1'b1;
        wr_sel[1]  = 5'd9;
        wr_data[1] = 32'h1999;
        apply();
        checks++;
        if (busy[9] !== 1'b0 || busy !== 32'h0) begin
            failures++;
            $display("FAIL write_clears got busy=%h want 0", busy);
        end
        idle();
        rd_en[0]  = 1'b1;
        rd_sel[0] = 5'd9;
        apply();
        expq.delete();
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[0] !== 32'h1999) begin
            failures++;
            $display("FAIL read_cleared got b=%b d=%h want b=0 d=1999", rd_busy[0], rd_data[0]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int c = 0; c < 400; c++) begin
            idle();
            wr_en      = 2'($urandom_range(0, 3));
            wr_sel[0]  = 5'($urandom_range(0, 31));
            wr_sel[1]  = ($urandom_range(0, 3) == 0) ? wr_sel[0] : 5'($urandom_range(0, 31));
            wr_data[0] = $urandom;
            wr_data[1] = $urandom;
            iss_en     = ($urandom_range(0, 2) == 0);
            iss_sel    = ($urandom_range(0, 3) == 0) ? wr_sel[0] : 5'($urandom_range(0, 31));
            rd_en      = 2'($urandom_range(0, 3));
            rd_sel[0]  = ($urandom_range(0, 2) == 0) ? wr_sel[0] : 5'($urandom_range(0, 31));
            rd_sel[1]  = ($urandom_range(0, 2) == 0) ? wr_sel[1] : 5'($urandom_range(0, 31));
            apply();
            while (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (rd_data[e.port] !== e.data || rd_busy[e.port] !== e.bsy) begin
                    failures++;
                    $display("FAIL b2b cyc=%0d port=%0d got d=%h b=%b want d=%h b=%b",
                             c, e.port, rd_data[e.port], rd_busy[e.port], e.data, e.bsy);
                end
            end
            checks++;
            if (rd_valid !== exp_vld || busy !== mbusy) begin
                failures++;
                $display("FAIL b2b_state cyc=%0d got valid=%b busy=%h want valid=%b busy=%h",
                         c, rd_valid, busy, exp_vld, mbusy);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        idle();
        wr_en[0]   = 1'b1;
        wr_sel[0]  = 5'd4;
        wr_data[0] = 32'h1234;
        apply();
        idle();
        iss_en  = 1'b1;
        iss_sel = 5'd4;
        apply();
        idle();
        rd_en[0]  = 1'b1;
        rd_sel[0] = 5'd4;
        apply();
        while (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (rd_valid[e.port] !== 1'b1 || rd_data[e.port] !== 32'h1234 || rd_busy[e.port] !== 1'b1) begin
                failures++;
                $display("FAIL pre_reset_read got v=%b d=%h b=%b want v=1 d=1234 b=1",
                         rd_valid[e.port], rd_data[e.port], rd_busy[e.port]);
            end
        end
        rd_en[0] = 1'b1;
        #2;
        n_rst_tb = 1'b1;
        #1;
        model_clear();
        checks++;
        if (rd_data !== '0 || rd_valid !== 2'b00 || rd_busy !== 2'b00 || busy !== 32'h0) begin
            failures++;
            $display("FAIL async_reset got data=%h valid=%b rbusy=%b busy=%h want all zero",
                     rd_data, rd_valid, rd_busy, busy);
        end
        @(posedge clk_tb);
        #1;
        checks++;
        if (rd_valid !== 2'b00 || busy !== 32'h0) begin
            failures++;
            $display("FAIL reset_held got valid=%b busy=%h want 00 0", rd_valid, busy);
        end
        n_rst_tb = 1'b0;
        idle();
        rd_en     = 2'b11;
        rd_sel[0] = 5'd4;
        rd_sel[1] = 5'd4;
        apply();
        while (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (rd_valid[e.port] !== 1'b1 || rd_data[e.port] !== 32'h0 || rd_busy[e.port] !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_read port=%0d got v=%b d=%h b=%b want v=1 d=0 b=0",
                         e.port, rd_valid[e.port], rd_data[e.port], rd_busy[e.port]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_write_all();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core: NRD synchronous read ports, NWR write ports, an optional hardwired-zero register and a per-register busy scoreboard for in-flight writes. It sits between decode/issue (reads, busy marking) and writeback (writes, busy clearing). It succeeds the single-write, dual-read register file with configurable width, depth and port counts, registered reads, deterministic write-collision priority and hazard tracking.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, >=2)
- NRD, 2, number of read ports (1..4)
- NWR, 1, number of write ports (1..2)
- ZERO_REG, 1, when 1, register 0 reads as zero and ignores writes and issues
- AW, $clog2(NREGS), derived select width (not to be overridden)

- clk_tb  in  1  clock; all state updates on rising edge
- n_rst_tb  in  1  reset, asynchronous, active-high
- rd_en  in  NRD  per-port read request
- rd_sel  in  NRD x AW  read register index
- rd_data  out  NRD x XLEN  registered read data
- rd_valid  out  NRD  rd_data updated this cycle (rd_en delayed one cycle)
- rd_busy  out  NRD  read register was busy at sample edge (hazard flag)
- wr_en  in  NWR  per-port write enable
- wr_sel  in  NWR x AW  write register index
- wr_data  in  NWR x XLEN  write data
- iss_en  in  1  mark a register as having a pending write
- iss_sel  in  AW  register to mark busy
- busy  out  NREGS  scoreboard vector, bit i = register i pending

## Operation
- Reset (n_rst_tb high, asynchronous): all registers 0, busy all 0, rd_data 0, rd_valid 0, rd_busy 0; held while asserted.
- Write: on rising edge, each port with wr_en high writes wr_data to wr_sel. Two ports same index same edge: higher port index wins.
- ZERO_REG=1: writes, issues to index 0 are dropped; reads of index 0 return 0, rd_busy 0.
- Read: on rising edge with rd_en[p] high, rd_data[p] <= contents of rd_sel[p]; rd_valid[p] <= 1. rd_en low: rd_data[p] holds, rd_valid[p] <= 0. Ports independent; any ports may read same index.
- Scoreboard: iss_en sets busy[iss_sel]; any write to index i clears busy[i]. Same edge issue and write to same index: busy stays set (new producer wins). Issue to already-busy register: stays set.
- rd_busy[p] <= busy[rd_sel[p]] at the read edge, after applying that edge's writes (i.e. a write clearing the register also clears the hazard) when bypass is enabled; otherwise pre-edge busy value.
- Indices >= NREGS impossible (NREGS power of two).

## Timing
- Read latency 1 cycle: rd_sel sampled at edge N, rd_data valid after edge N, until next enabled read.
- Write visible to non-bypassed read at edge N+1 when written at edge N.
- Busy set/clear visible on busy output after the edge.
- No handshake back-pressure; every request accepted every cycle.
- Reset mid-operation discards pending reads and scoreboard state immediately; first read after deassert returns 0.

## Configuration
- REGFILE_BYPASS_EN defined: read and write to same index on same edge return the new wr_data (highest-index winning port), and rd_busy reflects the clear from that write.
- Undefined: same-edge read returns old contents and old busy; bypass mux logic absent.

## Structure
- Package regfile_pkg: default XLEN/NREGS constants, AW helper function, typedefs for register word and index.
- Sub-module regfile_scoreboard: busy vector with set/clear priority; storage, read ports and bypass stay in regfile_mp.

## Test plan
- Reset with defaults then read all 32 indices on both ports -> rd_data 0, rd_valid 1 one cycle after each request, busy all 0.
- Write reg i = i+2 for i 0..31, then read -> reg 0 returns 0 (ZERO_REG=1), reg 5 returns 0x7, reg 31 returns 0x21.
- NWR=2, both ports write reg 3 same edge with 0xAAAA and 0x5555 -> reg 3 reads 0x5555.
- Write reg 7 = 0xDEADBEEF and read reg 7 same edge -> 0xDEADBEEF with REGFILE_BYPASS_EN, previous value without.
- iss_en reg 9 then read reg 9 -> rd_busy 1, busy[9] 1; write reg 9 and issue reg 9 same edge -> busy[9] stays 1; later write alone -> busy[9] 0.
- Assert n_rst_tb mid-sequence after writing reg 4 = 0x1234 and issuing reg 4 -> rd_data, rd_valid, busy cleared immediately; read reg 4 after deassert -> 0.
